// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the 16x16 register-file write port
//
// Purpose: shares the single register-file write port between requester 0
// (ALU result) and requester 1 (load data). Each requester uses a valid/ready
// handshake; an accepted request is staged into a registered write stage
// (regWr/rw/busW) one cycle later.
//
// Optional feature: define REGFILE_WB_BYPASS_EN to add read forwarding from the
// staged write to the two register-file read buses.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   hold                     freeze: no new grants while high
//   req0_valid/addr/data     ALU writeback request; req0_ready = accepted this cycle
//   req1_valid/addr/data     load writeback request; req1_ready = accepted this cycle
//   regWr, rw, busW          registered register-file write enable/address/data
//   wr_count                 saturating count of writes issued to the register file
//   rs, rt                   (bypass only) read addresses
//   busA_rf, busB_rf         (bypass only) register-file read data
//   busA_fwd, busB_fwd       (bypass only) read data with forwarding applied

module regfile_wb_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int ZERO_REG_RO = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              regWr,
    output logic [ADDR_W-1:0] rw,
    output logic [DATA_W-1:0] busW,
    output logic [CNT_W-1:0]  wr_count
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [DATA_W-1:0] busA_rf,
    input  logic [DATA_W-1:0] busB_rf,
    output logic [DATA_W-1:0] busA_fwd,
    output logic [DATA_W-1:0] busB_fwd
`endif
);

    // rrPtr names the requester that wins the next contested cycle.
    logic              rrPtr;
    logic              grant0;
    logic              grant1;
    logic              xfer;
    logic              issue;
    logic              zeroDest;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!hold) begin
            if (req0_valid && req1_valid) begin
                grant0 = !rrPtr;
                grant1 = rrPtr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;
    assign selAddr    = grant1 ? req1_addr : req0_addr;
    assign selData    = grant1 ? req1_data : req0_data;

    // Writes to $0 are accepted (handshake completes, pointer moves) but never
    // reach the register file, so they are not counted either.
    assign zeroDest   = (ZERO_REG_RO != 0) && (selAddr == '0);
    assign issue      = xfer && !zeroDest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWr    <= 1'b0;
            rw       <= '0;
            busW     <= '0;
            wr_count <= '0;
            rrPtr    <= 1'b0;
        end else begin
            regWr <= issue;
            if (xfer) begin
                rw    <= selAddr;
                busW  <= selData;
                // After serving requester k the other one is preferred.
                rrPtr <= grant0;
            end
            if (issue && (wr_count != {CNT_W{1'b1}})) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic fwdA;
    logic fwdB;

    assign fwdA     = regWr && (rw == rs) && !((ZERO_REG_RO != 0) && (rs == '0));
    assign fwdB     = regWr && (rw == rt) && !((ZERO_REG_RO != 0) && (rt == '0));
    assign busA_fwd = fwdA ? busW : busA_rf;
    assign busB_fwd = fwdB ? busW : busB_rf;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          regWr;
    logic [AW-1:0] rw;
    logic [DW-1:0] busW;
    logic [CW-1:0] wr_count;
`ifdef REGFILE_WB_BYPASS_EN
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] busA_rf;
    logic [DW-1:0] busB_rf;
    logic [DW-1:0] busA_fwd;
    logic [DW-1:0] busB_fwd;
`endif

    int nChecks = 0;
    int nFails  = 0;

    regfile_wb_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .ZERO_REG_RO(1), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .regWr(regWr), .rw(rw), .busW(busW), .wr_count(wr_count)
`ifdef REGFILE_WB_BYPASS_EN
        , .rs(rs), .rt(rt), .busA_rf(busA_rf), .busB_rf(busB_rf),
        .busA_fwd(busA_fwd), .busB_fwd(busB_fwd)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: which requester wins this cycle (-1 = none), the
    // preferred requester, and the expected write-stage contents.
    int            mPref;
    logic          mRegWr;
    logic [AW-1:0] mRw;
    logic [DW-1:0] mBusW;
    int            mCount;

    function automatic int winner();
        if (hold) return -1;
        if (req0_valid && req1_valid) return mPref;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            mPref  <= 0;
            mRegWr <= 1'b0;
            mRw    <= '0;
            mBusW  <= '0;
            mCount <= 0;
        end else begin
            w = winner();
            if (w < 0) begin
                mRegWr <= 1'b0;
            end else begin
                mPref  <= 1 - w;
                mRw    <= (w == 0) ? req0_addr : req1_addr;
                mBusW  <= (w == 0) ? req0_data : req1_data;
                if (((w == 0) ? req0_addr : req1_addr) != 0) begin
                    mRegWr <= 1'b1;
                    if (mCount < CMAX) mCount <= mCount + 1;
                end else begin
                    mRegWr <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int w;
        w = winner();
        chk("model.req0_ready", 32'(req0_ready), 32'(w == 0));
        chk("model.req1_ready", 32'(req1_ready), 32'(w == 1));
        chk("model.regWr", 32'(regWr), 32'(mRegWr));
        if (mRegWr) begin
            chk("model.rw", 32'(rw), 32'(mRw));
            chk("model.busW", 32'(busW), 32'(mBusW));
        end
        chk("model.wr_count", 32'(wr_count), 32'(mCount));
    end

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic h);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        hold = h;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int expG [4] = '{0, 1, 0, 1};
        logic [DW-1:0] expW [4] = '{16'h1111, 16'h2222, 16'h1112, 16'h2223};

        rst_n = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
        rs = '0; rt = '0; busA_rf = '0; busB_rf = '0;
`endif
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("reset.regWr", 32'(regWr), 32'd0);
        chk("reset.rw", 32'(rw), 32'd0);
        chk("reset.busW", 32'(busW), 32'd0);
        chk("reset.wr_count", 32'(wr_count), 32'd0);

        // Contention: grants alternate, regWr high four cycles in a row.
        d0 = 16'h1111;
        d1 = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, d0, 1, 2, d1, 0);
            chk("contend.ready0", 32'(req0_ready), 32'(expG[i] == 0));
            chk("contend.ready1", 32'(req1_ready), 32'(expG[i] == 1));
            step();
            chk("contend.regWr", 32'(regWr), 32'd1);
            chk("contend.busW", 32'(busW), 32'(expW[i]));
            if (expG[i] == 0) d0 = d0 + 16'd1; else d1 = d1 + 16'd1;
        end
        chk("contend.wr_count", 32'(wr_count), 32'd4);

        // Single requester.
        drive(1, 3, 16'hABCD, 0, 0, 0, 0);
        chk("single.ready0", 32'(req0_ready), 32'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("single.regWr", 32'(regWr), 32'd1);
        chk("single.rw", 32'(rw), 32'd3);
        chk("single.busW", 32'(busW), 32'hABCD);
        chk("single.wr_count", 32'(wr_count), 32'd5);
        step();
        chk("single.pulse_end", 32'(regWr), 32'd0);

        // Write to $0: accepted, never issued, pointer still moves to 0.
        drive(0, 0, 0, 1, 0, 16'hFFFF, 0);
        chk("zero.ready1", 32'(req1_ready), 32'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("zero.regWr", 32'(regWr), 32'd0);
        chk("zero.wr_count", 32'(wr_count), 32'd5);
        drive(1, 4, 16'h4444, 1, 6, 16'h6666, 0);
        chk("zero.ptr_toggled", 32'(req0_ready), 32'd1);
        step();

        // Hold with both valid; staged write still drains.
        drive(0, 0, 0, 1, 6, 16'h6666, 0);
        drive(1, 8, 16'h8888, 1, 6, 16'h6666, 1);
        for (int i = 0; i < 3; i++) begin
            chk("hold.ready0", 32'(req0_ready), 32'd0);
            chk("hold.ready1", 32'(req1_ready), 32'd0);
            if (i == 0) chk("hold.drain", 32'(regWr), 32'd1);
            step();
            chk("hold.regWr", 32'(regWr), 32'd0);
        end
        drive(1, 8, 16'h8888, 1, 6, 16'h6666, 0);
        chk("hold.release_ready1", 32'(req1_ready), 32'd1);
        chk("hold.release_ready0", 32'(req0_ready), 32'd0);
        step();

        // Same destination from both: two pulses, last write wins.
        drive(1, 7, 16'h0707, 1, 7, 16'h7070, 0);
        chk("same.ready0", 32'(req0_ready), 32'd1);
        step();
        chk("same.first", 32'(busW), 32'h0707);
        drive(0, 0, 0, 1, 7, 16'h7070, 0);
        chk("same.ready1", 32'(req1_ready), 32'd1);
        step();
        chk("same.second_regWr", 32'(regWr), 32'd1);
        chk("same.second_busW", 32'(busW), 32'h7070);
        chk("same.rw", 32'(rw), 32'd7);

        // Saturation of wr_count.
        drive(1, 1, 16'h0101, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("sat.wr_count", 32'(wr_count), 32'(CMAX));

`ifdef REGFILE_WB_BYPASS_EN
        drive(1, 5, 16'h00FF, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        rs = 5; busA_rf = 16'h1234; rt = 2; busB_rf = 16'h5678;
        #1;
        chk("byp.busA_hit", 32'(busA_fwd), 32'h00FF);
        chk("byp.busB_miss", 32'(busB_fwd), 32'h5678);
        rs = 6;
        rt = 5;
        #1;
        chk("byp.busA_miss", 32'(busA_fwd), 32'h1234);
        chk("byp.busB_hit", 32'(busB_fwd), 32'h00FF);
        step();
`endif

        // Asynchronous reset mid-cycle with a staged write pending.
        drive(1, 9, 16'h9999, 0, 0, 0, 0);
        step();
        chk("rst.staged", 32'(regWr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.regWr", 32'(regWr), 32'd0);
        chk("rst.rw", 32'(rw), 32'd0);
        chk("rst.busW", 32'(busW), 32'd0);
        chk("rst.wr_count", 32'(wr_count), 32'd0);
        step();
        rst_n = 1'b1;
        drive(1, 10, 16'hAAAA, 1, 11, 16'hBBBB, 0);
        chk("rst.first_grant0", 32'(req0_ready), 32'd1);
        chk("rst.first_grant1", 32'(req1_ready), 32'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst.first_busW", 32'(busW), 32'hAAAA);
        chk("rst.first_count", 32'(wr_count), 32'd1);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
